// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and constants for the data-RAM round-robin arbiter.
//   state_t    : arbiter FSM states (IDLE, ACCESS, RESP)
//   LAT_CW     : width of the read-latency wait counter (RD_LAT up to 3)
//   *_DEF      : default core count and RAM geometry
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int LAT_CW     = 2;
  localparam int NCORES_DEF = 3;
  localparam int AW_DEF     = 8;
  localparam int DW_DEF     = 8;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    : per-core request vector
//   rr_ptr : highest-priority core index for this pick
//   gnt    : one-hot grant
//   w      : index of the granted core
//   any    : at least one request present
module rr_pick
  import dram_arb_pkg::*;
#(
  parameter int NCORES = NCORES_DEF,
  parameter int PW     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic [NCORES-1:0] req,
  input  logic [PW-1:0]     rr_ptr,
  output logic [NCORES-1:0] gnt,
  output logic [PW-1:0]     w,
  output logic              any
);

  logic [PW-1:0] idx;

  // Walk rr_ptr, rr_ptr+1, ... (mod NCORES); the first requester found wins.
  always_comb begin
    gnt = '0;
    w   = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < NCORES; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NCORES);
      if (!any && req[idx]) begin
        any      = 1'b1;
        w        = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_rr_arbiter.sv
// dram_rr_arbiter: shares one single-port data RAM between NCORES cores.
//   clk, rst_n     : clock, synchronous active-low reset
//   req/we/addr/wdata : per-core request (held until done), slice i = core i
//   rdata          : per-core read data, updated only for served read cores
//   done           : one-cycle completion pulse, one bit per served core
//   busy           : high in ACCESS and RESP
//   ext_hold       : external master owns the RAM; blocks new grants in IDLE
//   ram_addr/ram_din/ram_wren/ram_q : RAM port (ram_q valid RD_LAT cycles
//                    after ram_addr is registered)
// Reads to the same address as a read winner are coalesced into one RAM
// access; writes are always served alone.
module dram_rr_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NCORES = NCORES_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES-1:0]    we,
  input  logic [NCORES*AW-1:0] addr,
  input  logic [NCORES*DW-1:0] wdata,
  output logic [NCORES*DW-1:0] rdata,
  output logic [NCORES-1:0]    done,
  output logic                 busy,
  input  logic                 ext_hold,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_din,
  output logic                 ram_wren,
  input  logic [DW-1:0]        ram_q
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  state_t              state;
  logic [PW-1:0]       rr_ptr;
  logic [NCORES-1:0]   served;
  logic                is_wr;
  logic [LAT_CW-1:0]   cnt;

  logic [NCORES-1:0]   gnt, match, served_nxt;
  logic [PW-1:0]       w;
  logic                any;
  logic [AW-1:0]       w_addr;
  logic [DW-1:0]       w_wdata;
  logic                w_we;

  rr_pick #(.NCORES(NCORES), .PW(PW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (gnt),
    .w      (w),
    .any    (any)
  );

  assign w_addr  = addr[int'(w)*AW +: AW];
  assign w_wdata = wdata[int'(w)*DW +: DW];
  assign w_we    = we[w];

  // Cores that can ride along on the winner's read.
  for (genvar i = 0; i < NCORES; i++) begin : g_cmp
    assign match[i] = req[i] && !we[i] && (addr[i*AW +: AW] == w_addr);
  end

  assign served_nxt = w_we ? gnt : (gnt | match);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      served   <= '0;
      is_wr    <= 1'b0;
      cnt      <= '0;
      rdata    <= '0;
      done     <= '0;
      busy     <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_wren <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ram_wren <= 1'b0;
          done     <= '0;
          if (!ext_hold && any) begin
            ram_addr <= w_addr;
            ram_din  <= w_wdata;
            ram_wren <= w_we;
            is_wr    <= w_we;
            served   <= served_nxt;
            // Only the winner advances the pointer; coalesced cores do not.
            rr_ptr   <= (int'(w) == NCORES-1) ? '0 : w + PW'(1);
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (is_wr) begin
            ram_wren <= 1'b0;
            done     <= served;
            state    <= RESP;
          end else if (cnt == LAT_CW'(RD_LAT)) begin
            // Address was presented in the first ACCESS cycle; ram_q is
            // valid RD_LAT cycles later, which is this cycle.
            for (int i = 0; i < NCORES; i++)
              if (served[i]) rdata[i*DW +: DW] <= ram_q;
            done  <= served;
            state <= RESP;
          end else begin
            cnt <= cnt + LAT_CW'(1);
          end
        end
        RESP: begin
          done  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
